// File: rtl/light_pkg.sv
// Shared state encoding and lamp decode for the signal-head sequencer.
package light_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_RED        = 3'd0,
        ST_RED_YELLOW = 3'd1,
        ST_GREEN      = 3'd2,
        ST_YELLOW     = 3'd3,
        ST_NIGHT      = 3'd4,
        ST_FAULT      = 3'd5
    } state_e;

    typedef struct packed {
        logic red_en;
        logic red_off;
        logic yel_en;
        logic yel_off;
        logic grn_en;
        logic grn_off;
    } lamps_t;

    // Flasher (enable, off_state) pairs for each state; unknown codes show RED.
    function automatic lamps_t lamp_decode(input state_e st);
        lamps_t l;
        l = '0;
        case (st)
            ST_RED:        l.red_off = 1'b1;
            ST_RED_YELLOW: begin
                l.red_off = 1'b1;
                l.yel_off = 1'b1;
            end
            ST_GREEN:      l.grn_off = 1'b1;
            ST_YELLOW:     l.yel_off = 1'b1;
            ST_NIGHT:      l.yel_en  = 1'b1;
            ST_FAULT:      l.red_en  = 1'b1;
            default:       l.red_off = 1'b1;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick every DIV clocks; clear restarts the count.
module tick_prescaler #(
    parameter int unsigned DIV = 50000000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/light_sequencer.sv
// Signal-head sequencer: RED -> RED_YELLOW -> GREEN -> YELLOW -> RED, with
// night (yellow flashing) and fault (red flashing) overrides driving three lamp flashers.
module light_sequencer
    import light_pkg::*;
#(
    parameter int unsigned TICK_DIV         = 50000000,
    parameter int unsigned RED_TICKS        = 10,
    parameter int unsigned RED_YELLOW_TICKS = 2,
    parameter int unsigned GREEN_TICKS      = 10,
    parameter int unsigned YELLOW_TICKS     = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               night_mode,
    input  logic               fault,
    output logic               red_enable,
    output logic               red_off_state,
    output logic               yellow_enable,
    output logic               yellow_off_state,
    output logic               green_enable,
    output logic               green_off_state,
    output logic [STATE_W-1:0] state,
    output logic               phase_done
);

    localparam int unsigned MAX_A = (RED_TICKS > RED_YELLOW_TICKS) ? RED_TICKS : RED_YELLOW_TICKS;
    localparam int unsigned MAX_B = (GREEN_TICKS > YELLOW_TICKS) ? GREEN_TICKS : YELLOW_TICKS;
    localparam int unsigned MAX_D = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned PH_W  = $clog2(MAX_D) + 1;

    state_e          state_q, state_d;
    logic [PH_W-1:0] ph_q, ph_d;
    lamps_t          lamps_q, lamps_d;
    logic            tick, entry, timed, phase_end;

    function automatic logic [PH_W-1:0] phase_load(input state_e st);
        case (st)
            ST_RED_YELLOW: return PH_W'(RED_YELLOW_TICKS - 1);
            ST_GREEN:      return PH_W'(GREEN_TICKS - 1);
            ST_YELLOW:     return PH_W'(YELLOW_TICKS - 1);
            default:       return PH_W'(RED_TICKS - 1);
        endcase
    endfunction

    tick_prescaler #(
        .DIV (TICK_DIV)
    ) u_prescaler (
        .clock (clock),
        .reset (reset),
        .clear (entry),
        .tick  (tick)
    );

    always_comb begin
        timed     = (state_q == ST_RED) || (state_q == ST_RED_YELLOW) ||
                    (state_q == ST_GREEN) || (state_q == ST_YELLOW);
        phase_end = tick && timed && (ph_q == '0);
        state_d   = state_q;
        case (state_q)
            ST_RED:        if (phase_end) state_d = night_mode ? ST_NIGHT : ST_RED_YELLOW;
            ST_RED_YELLOW: if (phase_end) state_d = ST_GREEN;
            ST_GREEN:      if (phase_end) state_d = ST_YELLOW;
            ST_YELLOW:     if (phase_end) state_d = ST_RED;
            ST_NIGHT:      if (!night_mode) state_d = ST_RED;
            ST_FAULT:      if (!fault) state_d = ST_RED;
            default:       state_d = ST_RED;
        endcase
        if (fault) begin
            state_d = ST_FAULT;
        end

        // Any state change restarts both the prescaler and the phase count.
        entry = (state_d != state_q);
        ph_d  = ph_q;
        if (entry) begin
            ph_d = phase_load(state_d);
        end else if (tick && (ph_q != '0)) begin
            ph_d = ph_q - 1'b1;
        end

        lamps_d = lamp_decode(state_d);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_RED;
            ph_q    <= PH_W'(RED_TICKS - 1);
            lamps_q <= lamp_decode(ST_RED);
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            lamps_q <= lamps_d;
        end
    end

    assign state            = state_q;
    assign phase_done       = phase_end;
    assign red_enable       = lamps_q.red_en;
    assign red_off_state    = lamps_q.red_off;
    assign yellow_enable    = lamps_q.yel_en;
    assign yellow_off_state = lamps_q.yel_off;
    assign green_enable     = lamps_q.grn_en;
    assign green_off_state  = lamps_q.grn_off;

endmodule

// File: tb/tb_light_sequencer.sv
// Directed bench for light_sequencer with TICK_DIV=4, RED=3, RED_YELLOW=1, GREEN=3, YELLOW=1.
module tb_light_sequencer;
    import light_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       night_mode;
    logic       fault;
    logic       red_enable, red_off_state;
    logic       yellow_enable, yellow_off_state;
    logic       green_enable, green_off_state;
    logic [2:0] state;
    logic       phase_done;
    logic [5:0] lamp_bus;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // {red_en, red_off, yel_en, yel_off, grn_en, grn_off}
    localparam logic [5:0] L_RED    = 6'b010000;
    localparam logic [5:0] L_RY     = 6'b010100;
    localparam logic [5:0] L_GREEN  = 6'b000001;
    localparam logic [5:0] L_YELLOW = 6'b000100;
    localparam logic [5:0] L_NIGHT  = 6'b001000;
    localparam logic [5:0] L_FAULT  = 6'b100000;

    always #5 clock = ~clock;

    light_sequencer #(
        .TICK_DIV         (4),
        .RED_TICKS        (3),
        .RED_YELLOW_TICKS (1),
        .GREEN_TICKS      (3),
        .YELLOW_TICKS     (1)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .night_mode       (night_mode),
        .fault            (fault),
        .red_enable       (red_enable),
        .red_off_state    (red_off_state),
        .yellow_enable    (yellow_enable),
        .yellow_off_state (yellow_off_state),
        .green_enable     (green_enable),
        .green_off_state  (green_off_state),
        .state            (state),
        .phase_done       (phase_done)
    );

    assign lamp_bus = {red_enable, red_off_state, yellow_enable, yellow_off_state,
                       green_enable, green_off_state};

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [2:0] code);
        check_val(tag, {5'd0, state}, {5'd0, code});
    endtask

    task automatic check_lamps(input string tag, input logic [5:0] exp);
        check_val(tag, {2'b00, lamp_bus}, {2'b00, exp});
    endtask

    task automatic check_pd(input string tag, input logic exp);
        check_val(tag, {7'd0, phase_done}, {7'd0, exp});
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Expects to be called in the first cycle of a timed phase; returns in the first cycle of the next.
    task automatic run_phase(input string name, input logic [2:0] code, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            check_state($sformatf("%s_state_c%0d", name, i + 1), code);
            check_pd($sformatf("%s_pd_c%0d", name, i + 1), (i == n - 1));
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        night_mode = 1'b0;
        fault      = 1'b0;
        step();
        check_state("rst_state", 3'd0);
        check_lamps("rst_lamps", L_RED);
        check_pd("rst_pd", 1'b0);
        step();
        reset = 1'b0;

        // 1: normal 32-cycle loop
        check_lamps("t1_red_lamps", L_RED);
        run_phase("t1_red", 3'd0, 12);
        check_lamps("t1_ry_lamps", L_RY);
        run_phase("t1_ry", 3'd1, 4);
        check_lamps("t1_green_lamps", L_GREEN);
        run_phase("t1_green", 3'd2, 12);
        check_lamps("t1_yellow_lamps", L_YELLOW);
        run_phase("t1_yellow", 3'd3, 4);
        check_state("t1_back_red", 3'd0);
        check_lamps("t1_back_red_lamps", L_RED);

        // 2: night requested during GREEN
        run_phase("t2_red0", 3'd0, 12);
        run_phase("t2_ry0", 3'd1, 4);
        night_mode = 1'b1;
        run_phase("t2_green", 3'd2, 12);
        run_phase("t2_yellow", 3'd3, 4);
        run_phase("t2_red", 3'd0, 12);
        check_state("t2_night", 3'd4);
        check_lamps("t2_night_lamps", L_NIGHT);
        for (int i = 0; i < 3; i++) begin
            step();
            check_state($sformatf("t2_night_hold%0d", i), 3'd4);
            check_pd($sformatf("t2_night_pd%0d", i), 1'b0);
        end
        night_mode = 1'b0;
        step();
        check_state("t2_exit_red", 3'd0);
        check_lamps("t2_exit_red_lamps", L_RED);
        run_phase("t2_red_after", 3'd0, 12);
        check_state("t2_ry_after", 3'd1);

        // 3: one-cycle fault pulse in GREEN cycle 5
        run_phase("t3_ry", 3'd1, 4);
        for (int i = 0; i < 4; i++) begin
            check_state($sformatf("t3_green_c%0d", i + 1), 3'd2);
            step();
        end
        fault = 1'b1;
        step();
        check_state("t3_fault", 3'd5);
        check_lamps("t3_fault_lamps", L_FAULT);
        fault = 1'b0;
        step();
        check_state("t3_red", 3'd0);
        check_lamps("t3_red_lamps", L_RED);
        run_phase("t3_red_full", 3'd0, 12);
        check_state("t3_ry_after", 3'd1);

        // 4: fault coincides with RED phase end
        run_phase("t4_ry", 3'd1, 4);
        run_phase("t4_green", 3'd2, 12);
        run_phase("t4_yellow", 3'd3, 4);
        repeat (11) step();
        check_state("t4_red_last", 3'd0);
        check_pd("t4_pd", 1'b1);
        fault = 1'b1;
        step();
        check_state("t4_fault", 3'd5);
        fault = 1'b0;
        step();
        check_state("t4_red", 3'd0);
        run_phase("t4_red_full", 3'd0, 12);

        // 5: asynchronous reset mid-YELLOW
        run_phase("t5_ry", 3'd1, 4);
        run_phase("t5_green", 3'd2, 12);
        check_state("t5_yellow", 3'd3);
        step();
        #2;
        reset = 1'b1;
        #1;
        check_state("t5_async_state", 3'd0);
        check_lamps("t5_async_lamps", L_RED);
        check_pd("t5_async_pd", 1'b0);
        step();
        reset = 1'b0;
        run_phase("t5_red", 3'd0, 12);
        check_state("t5_ry_after", 3'd1);

        // 6: illegal state code recovers to RED
        step();
        dut.state_q = state_e'(3'd7);
        step();
        check_state("t6_recover", 3'd0);
        check_lamps("t6_recover_lamps", L_RED);
        run_phase("t6_red", 3'd0, 12);
        check_state("t6_ry_after", 3'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/light_sequencer.md
Name: light_sequencer

Overview:
- Control-side initiator for the lamp flashers: sequences one signal head through RED -> RED_YELLOW -> GREEN -> YELLOW -> RED.
- Drives each lamp flasher's enable and out_state_when_enable_off inputs.
- Supports night mode (yellow flashing) and fault mode (red flashing).
- Sits between the mode/fault inputs and three flasher instances (red, yellow, green) in the top level.

Parameters:
- TICK_DIV, 50000000, clock cycles per timing tick (1 s at 50 MHz); must be >= 1.
- RED_TICKS, 10, RED phase length in ticks; must be >= 1.
- RED_YELLOW_TICKS, 2, RED_YELLOW phase length in ticks; must be >= 1.
- GREEN_TICKS, 10, GREEN phase length in ticks; must be >= 1.
- YELLOW_TICKS, 3, YELLOW phase length in ticks; must be >= 1.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- night_mode  input  1  request yellow flashing; synchronous to clock (synchronised upstream).
- fault  input  1  force red flashing; synchronous to clock.
- red_enable  output  1  red flasher enable.
- red_off_state  output  1  red lamp level while red_enable=0.
- yellow_enable  output  1  yellow flasher enable.
- yellow_off_state  output  1  yellow lamp level while yellow_enable=0.
- green_enable  output  1  green flasher enable.
- green_off_state  output  1  green lamp level while green_enable=0.
- state  output  3  current state code.
- phase_done  output  1  one-cycle pulse on the cycle a timed phase ends.

Behaviour:
- States and codes: RED=0, RED_YELLOW=1, GREEN=2, YELLOW=3, NIGHT=4, FAULT=5. Codes 6-7 are illegal; the FSM recovers from them to RED on the next edge.
- Reset (async assert, sync release): state=RED, red_off_state=1, all other outputs 0, prescaler=0, phase counter loaded.
- Lamp outputs:
  - Registered; they change on the same edge as state.
  - Per state, as (enable, off_state) for red / yellow / green:
    - RED: red (0,1); yellow (0,0); green (0,0).
    - RED_YELLOW: red (0,1); yellow (0,1); green (0,0).
    - GREEN: red (0,0); yellow (0,0); green (0,1).
    - YELLOW: red (0,0); yellow (0,1); green (0,0).
    - NIGHT: red (0,0); yellow (1,0); green (0,0).
    - FAULT: red (1,0); yellow (0,0); green (0,0).
- Prescaler:
  - Counts 0..TICK_DIV-1 and produces a tick on the count TICK_DIV-1.
  - Cleared on every state entry, so phase timing is exact.
- Phase counter:
  - Width $clog2(max duration)+1.
  - Loaded with DURATION-1 on state entry.
  - On tick: if 0, the phase ends; otherwise it decrements.
  - Each timed phase therefore lasts exactly DURATION*TICK_DIV cycles.
- Timed transitions at phase end (phase_done=1 for that cycle):
  - RED -> NIGHT if night_mode=1, else RED -> RED_YELLOW.
  - RED_YELLOW -> GREEN.
  - GREEN -> YELLOW.
  - YELLOW -> RED.
- night_mode is sampled only at RED phase end. Asserting it mid-cycle completes the normal sequence to RED first.
- NIGHT: untimed, no phase_done. When night_mode=0, the next edge enters RED with a full RED_TICKS load.
- FAULT:
  - fault=1 in any state causes entry to FAULT on the next edge. It has priority over timed transitions and night_mode.
  - While fault=1, FAULT is held.
  - When fault=0, the next edge enters RED (full load), regardless of night_mode.
- Simultaneous events: fault and phase end on the same edge -> FAULT, but phase_done still pulses.
- Reset mid-phase: immediate return to reset values; the sequence restarts at RED with a full count.

Decomposition:
- Package light_pkg: state encoding localparams (ST_RED..ST_FAULT), STATE_W=3.
- Sub-module tick_prescaler, parameter DIV:
  - Ports: clock, reset, clear, tick.
  - Instantiated once.
- FSM and phase counter stay in light_sequencer.

Test Plan (TICK_DIV=4, RED=3, RED_YELLOW=1, GREEN=3, YELLOW=1):
1. Reset, then release with night_mode=0, fault=0:
   - state=0, red_off_state=1 for 12 cycles.
   - phase_done pulses once.
   - Then state=1 for 4 cycles, state=2 for 12, state=3 for 4, back to 0.
   - Full loop is 32 cycles.
2. Assert night_mode during GREEN:
   - GREEN and YELLOW complete, RED runs 12 cycles, then state=4 with yellow_enable=1 and all off_states=0.
   - Drop night_mode -> state=0 next edge, RED lasts 12 cycles.
3. Pulse fault for 1 cycle at GREEN cycle 5:
   - Next edge state=5 with red_enable=1.
   - Following edge state=0 with red_off_state=1; RED lasts 12 cycles.
4. fault asserted on the exact cycle RED phase_done fires:
   - phase_done=1 and next state=5, not 1.
5. Assert reset asynchronously mid-YELLOW, between clock edges:
   - Outputs reach reset values without waiting for an edge.
   - After release, a full 12-cycle RED.
6. Force state to 7 via a bench-only hierarchical deposit:
   - Next edge state=0 and the outputs decode to RED.
